// File: rtl/tran_bank_pkg.sv
// Shared configuration encoding for the tran_bank pass-switch lanes.
package tran_bank_pkg;

  localparam int unsigned LANE_CFG_BITS = 2;
  localparam int unsigned CFG_EN        = 1;
  localparam int unsigned CFG_DIR       = 0;

  localparam logic DIR_L2R = 1'b0;
  localparam logic DIR_R2L = 1'b1;

  // Field order matches the chain layout: en is the upper bit of each lane slot.
  typedef struct packed {
    logic en;
    logic dir;
  } lane_cfg_t;

endpackage

// File: rtl/tran_lane.sv
// One resolved pass-switch lane: out/oe muxing, both side keepers and a sticky contention flag.
module tran_lane
  import tran_bank_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  lane_cfg_t i_cfg,
  input  logic      i_clear,
  input  logic      i_left_in,
  input  logic      i_right_in,
  input  logic      i_left_drive,
  input  logic      i_right_drive,
  output logic      o_left_out,
  output logic      o_right_out,
  output logic      o_left_oe,
  output logic      o_right_oe,
  output logic      o_contention
);

  logic r_lkeep;
  logic r_rkeep;
  logic r_contention;
  logic w_l2r;
  logic w_r2l;
  logic w_set;

  assign w_l2r = i_cfg.en && (i_cfg.dir == DIR_L2R);
  assign w_r2l = i_cfg.en && (i_cfg.dir == DIR_R2L);
  // Conflict is judged on the receiving side only, against the config active this cycle.
  assign w_set = (w_l2r && i_right_drive) || (w_r2l && i_left_drive);

  always_comb begin
    o_left_out  = r_lkeep;
    o_right_out = r_rkeep;
    o_left_oe   = 1'b0;
    o_right_oe  = 1'b0;
    if (w_l2r) begin
      o_right_out = i_left_in;
      o_right_oe  = 1'b1;
    end else if (w_r2l) begin
      o_left_out = i_right_in;
      o_left_oe  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lkeep      <= 1'b0;
      r_rkeep      <= 1'b0;
      r_contention <= 1'b0;
    end else begin
      if (w_l2r) r_rkeep <= i_left_in;
      if (w_r2l) r_lkeep <= i_right_in;
      r_contention <= w_set || (r_contention && !i_clear);
    end
  end

  assign o_contention = r_contention;

endmodule

// File: rtl/tran_bank.sv
// Bank of WIDTH pass-switch lanes behind a serially shifted, atomically committed config chain.
module tran_bank
  import tran_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_shift,
  input  logic             cfg_in,
  input  logic             cfg_commit,
  output logic             cfg_out,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  input  logic [WIDTH-1:0] left_drive,
  input  logic [WIDTH-1:0] right_drive,
  output logic [WIDTH-1:0] left_out,
  output logic [WIDTH-1:0] right_out,
  output logic [WIDTH-1:0] left_oe,
  output logic [WIDTH-1:0] right_oe,
  output logic [WIDTH-1:0] contention
);

  localparam int unsigned CHAIN_W = LANE_CFG_BITS * WIDTH;

  logic [CHAIN_W-1:0] r_shadow;
  logic [CHAIN_W-1:0] r_active;

  // Commit samples the shadow before this edge's shift lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (cfg_shift)  r_shadow <= {r_shadow[CHAIN_W-2:0], cfg_in};
      if (cfg_commit) r_active <= r_shadow;
    end
  end

  assign cfg_out = r_shadow[CHAIN_W-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    lane_cfg_t w_cfg;
    assign w_cfg = lane_cfg_t'(r_active[LANE_CFG_BITS*g +: LANE_CFG_BITS]);

    tran_lane u_lane (
      .clk           (clk),
      .reset         (reset),
      .i_cfg         (w_cfg),
      .i_clear       (cfg_commit),
      .i_left_in     (left_in[g]),
      .i_right_in    (right_in[g]),
      .i_left_drive  (left_drive[g]),
      .i_right_drive (right_drive[g]),
      .o_left_out    (left_out[g]),
      .o_right_out   (right_out[g]),
      .o_left_oe     (left_oe[g]),
      .o_right_oe    (right_oe[g]),
      .o_contention  (contention[g])
    );
  end

endmodule

// File: tb/tb_tran_bank.sv
// Scoreboard bench for tran_bank: per-cycle expectations from a lane-level model, checked at negedge.
module tb_tran_bank;

  localparam int W = 8;
  localparam int CW = 2 * W;

  logic          clk = 1'b0;
  logic          reset, cfg_shift, cfg_in, cfg_commit, cfg_out;
  logic [W-1:0]  left_in, right_in, left_drive, right_drive;
  logic [W-1:0]  left_out, right_out, left_oe, right_oe, contention;

  always #5 clk = ~clk;

  tran_bank #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cfg_shift(cfg_shift), .cfg_in(cfg_in),
    .cfg_commit(cfg_commit), .cfg_out(cfg_out),
    .left_in(left_in), .right_in(right_in),
    .left_drive(left_drive), .right_drive(right_drive),
    .left_out(left_out), .right_out(right_out),
    .left_oe(left_oe), .right_oe(right_oe), .contention(contention)
  );

  typedef struct {
    logic [W-1:0] lo, ro, loe, roe, ct;
    logic         co;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: chain as plain bits, per-lane keepers/flags as arrays.
  logic [CW-1:0] m_sh, m_act;
  bit            m_lk[W], m_rk[W], m_ct[W];
  bit            m_valid = 0;
  logic [W-1:0]  s_lin = '0, s_rin = '0, s_ld = '0, s_rd = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("left_out",   left_out,   e.lo);
      chk("right_out",  right_out,  e.ro);
      chk("left_oe",    left_oe,    e.loe);
      chk("right_oe",   right_oe,   e.roe);
      chk("contention", contention, e.ct);
      chk("cfg_out",    W'(cfg_out), W'(e.co));
    end
  end

  // Drive one cycle, post its expected outputs, then advance the model across the edge.
  task automatic cyc(input logic sh, input logic din, input logic cm, input logic rst);
    exp_t e;
    cfg_shift = sh; cfg_in = din; cfg_commit = cm; reset = rst;
    left_in = s_lin; right_in = s_rin; left_drive = s_ld; right_drive = s_rd;
    if (m_valid) begin
      for (int i = 0; i < W; i++) begin
        bit en, r2l;
        en  = m_act[2*i+1];
        r2l = m_act[2*i];
        e.lo[i]  = (en && r2l)  ? s_rin[i] : m_lk[i];
        e.ro[i]  = (en && !r2l) ? s_lin[i] : m_rk[i];
        e.loe[i] = en && r2l;
        e.roe[i] = en && !r2l;
        e.ct[i]  = m_ct[i];
      end
      e.co = m_sh[CW-1];
      q.push_back(e);
    end
    if (rst) begin
      m_sh = '0; m_act = '0; m_valid = 1;
      for (int i = 0; i < W; i++) begin m_lk[i] = 0; m_rk[i] = 0; m_ct[i] = 0; end
    end else begin
      for (int i = 0; i < W; i++) begin
        bit en, r2l, hit;
        en  = m_act[2*i+1];
        r2l = m_act[2*i];
        hit = 0;
        if (en && !r2l) begin m_rk[i] = s_lin[i]; hit = s_rd[i]; end
        if (en && r2l)  begin m_lk[i] = s_rin[i]; hit = s_ld[i]; end
        m_ct[i] = hit || (m_ct[i] && !cm);
      end
      if (cm) m_act = m_sh;
      if (sh) m_sh = {m_sh[CW-2:0], din};
    end
    @(posedge clk);
    #1;
  endtask

  // Shift a word MSB first; optionally commit or reset while bit index k is being shifted.
  task automatic shift_word(input logic [CW-1:0] w, input int cm_at, input int rst_at);
    for (int k = CW - 1; k >= 0; k--) cyc(1'b1, w[k], k == cm_at, k == rst_at);
  endtask

  task automatic commit_idle(input int idles);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < idles; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Lane 0 right->left.
    shift_word(16'h0003, -1, -1);
    s_rin = 8'h01;
    commit_idle(1);
    shift_word(16'h0000, -1, -1);
    commit_idle(0);
    s_rin = 8'h00;
    cyc(0, 0, 0, 0);
    shift_word(16'h0003, -1, -1);
    commit_idle(1);

    // Lane 3 direction flip with keepers retained.
    s_lin = 8'h08;
    shift_word(16'h0080, -1, -1);
    commit_idle(1);
    shift_word(16'h00C0, -1, -1);
    s_rin = 8'h00;
    commit_idle(2);

    // Lane 5 contention set, held through a commit, then cleared.
    s_lin = '0;
    shift_word(16'h0800, -1, -1);
    commit_idle(0);
    s_rd = 8'h20;
    cyc(0, 0, 0, 0);
    s_rd = '0;
    cyc(0, 0, 0, 0);
    s_rd = 8'h20;
    commit_idle(0);
    s_rd = '0;
    cyc(0, 0, 0, 0);
    commit_idle(1);

    // cfg_out replay, commit during shift, reset mid-shift.
    shift_word(16'hA5A5, -1, -1);
    shift_word(16'h5A5A, 7, -1);
    cyc(0, 0, 0, 0);
    shift_word(16'hFFFF, -1, 8);
    cyc(0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      s_lin = W'($urandom); s_rin = W'($urandom);
      s_ld  = W'($urandom_range(0, 3) == 0 ? $urandom : 0);
      s_rd  = W'($urandom_range(0, 3) == 0 ? $urandom : 0);
      cyc(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 99) == 0));
    end

    cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
